// File: rtl/line_buffer_ctrl_pkg.sv
// Shared types for the line buffer controller: frame sequencer states and pointer width.
package lb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } lb_state_e;

    localparam int unsigned PTR_W = 3;

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Pixel stream in, column stream out, plus frame control/status for line_buffer_ctrl.
interface line_buffer_ctrl_if #(
    parameter int unsigned KER_SIZE = 3,
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned AW       = 8
) ();
    import lb_pkg::*;

    logic                         start;
    logic [AW-1:0]                img_width;
    logic [AW-1:0]                img_height;
    logic                         pix_valid;
    logic [BITWIDTH-1:0]          pix_data;
    logic                         pix_ready;
    logic [BITWIDTH*KER_SIZE-1:0] col_out;
    logic                         col_valid;
    logic [PTR_W-1:0]             col_ptr;
    logic [PTR_W-1:0]             init_col_ptr;
    logic                         busy;
    logic                         cfg_err;
    logic                         frame_done;

    modport master (
        output start, img_width, img_height, pix_valid, pix_data,
        input  pix_ready, col_out, col_valid, col_ptr, init_col_ptr, busy, cfg_err, frame_done
    );

    modport slave (
        input  start, img_width, img_height, pix_valid, pix_data,
        output pix_ready, col_out, col_valid, col_ptr, init_col_ptr, busy, cfg_err, frame_done
    );

endinterface

// File: rtl/line_buffer_ctrl_line_mem.sv
// One row of pixel storage: register array, combinational read, synchronous write.
module line_mem #(
    parameter int unsigned AW       = 8,
    parameter int unsigned BITWIDTH = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [BITWIDTH-1:0] wdata,
    output logic [BITWIDTH-1:0] rdata
);

    logic [BITWIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Same address for read and write: the old row is read out before it is replaced.
    assign rdata = mem[addr];

endmodule

// File: rtl/line_buffer_ctrl.sv
// Raster-stream line buffer controller: keeps KER_SIZE-1 rows in circular line memories and
// emits one KER_SIZE-tall column per accepted pixel with window-array pointer sideband.
module line_buffer_ctrl
    import lb_pkg::*;
#(
    parameter int unsigned KER_SIZE = 3,
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned AW       = 8
) (
    input logic               clk,
    input logic               rstn,
    line_buffer_ctrl_if.slave bus
);

    localparam int unsigned NL = KER_SIZE - 1;
    localparam int unsigned LW = (NL > 1) ? $clog2(NL) : 1;
    localparam int unsigned CW = BITWIDTH * KER_SIZE;

    localparam logic [AW-1:0]    KMIN      = AW'(KER_SIZE);
    localparam logic [AW-1:0]    FILL_LAST = AW'(KER_SIZE - 2);
    localparam logic [LW-1:0]    LINE_LAST = LW'(NL - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(KER_SIZE - 1);

    lb_state_e           state_q, state_d;
    logic [AW-1:0]       w_q, w_d, h_q, h_d, x_q, x_d, row_q, row_d;
    logic [LW-1:0]       wr_line_q, wr_line_d;
    logic [CW-1:0]       col_q, col_d, col_next;
    logic [PTR_W-1:0]    ptr_q, ptr_d, init_q, init_d;
    logic                col_valid_q, col_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                cfg_err_q, cfg_err_d;
    logic                ready, busy, accept, row_end, last_row, dims_ok;
    logic [LW:0]         sel_sum;
    logic [NL-1:0]       we;
    logic [BITWIDTH-1:0] rd_data [NL];

    assign accept   = bus.pix_valid && ready;
    assign row_end  = (x_q == w_q - AW'(1));
    assign last_row = (row_q == h_q - AW'(1));
    assign dims_ok  = (bus.img_width >= KMIN) && (bus.img_height >= KMIN);

    for (genvar i = 0; i < NL; i++) begin : g_line
        assign we[i] = accept && (wr_line_q == LW'(i));
        line_mem #(
            .AW       (AW),
            .BITWIDTH (BITWIDTH)
        ) u_line_mem (
            .clk   (clk),
            .we    (we[i]),
            .addr  (x_q),
            .wdata (bus.pix_data),
            .rdata (rd_data[i])
        );
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start && dims_ok) state_d = FILL;
            FILL:    if (accept && row_end && row_q == FILL_LAST) state_d = STREAM;
            STREAM:  if (accept && row_end && last_row) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready = (state_q == FILL) || (state_q == STREAM);
        busy  = (state_q != IDLE);
    end

    // Slice k comes from line (wr_line+k) mod NL: oldest row first, current pixel on top.
    always_comb begin
        col_next = '0;
        sel_sum  = '0;
        for (int unsigned k = 0; k < NL; k++) begin
            sel_sum = {1'b0, wr_line_q} + (LW+1)'(k);
            if (sel_sum >= (LW+1)'(NL)) sel_sum = sel_sum - (LW+1)'(NL);
            col_next[k*BITWIDTH +: BITWIDTH] = rd_data[sel_sum[LW-1:0]];
        end
        col_next[NL*BITWIDTH +: BITWIDTH] = bus.pix_data;
    end

    always_comb begin
        w_d          = w_q;
        h_d          = h_q;
        x_d          = x_q;
        row_d        = row_q;
        wr_line_d    = wr_line_q;
        col_d        = col_q;
        ptr_d        = ptr_q;
        init_d       = init_q;
        col_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        cfg_err_d    = 1'b0;
        if (state_q == IDLE && bus.start) begin
            if (dims_ok) begin
                w_d       = bus.img_width;
                h_d       = bus.img_height;
                x_d       = '0;
                row_d     = '0;
                wr_line_d = '0;
                ptr_d     = '0;
                init_d    = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
        if (accept) begin
            if (row_end) begin
                x_d       = '0;
                row_d     = row_q + AW'(1);
                wr_line_d = (wr_line_q == LINE_LAST) ? '0 : wr_line_q + LW'(1);
            end else begin
                x_d = x_q + AW'(1);
            end
            if (state_q == STREAM) begin
                col_valid_d  = 1'b1;
                col_d        = col_next;
                frame_done_d = row_end && last_row;
                if (x_q == '0) begin
                    ptr_d  = '0;
                    init_d = '0;
                end else begin
                    ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
                    init_d = (init_q == PTR_LAST) ? init_q : init_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_q          <= '0;
            h_q          <= '0;
            x_q          <= '0;
            row_q        <= '0;
            wr_line_q    <= '0;
            col_q        <= '0;
            ptr_q        <= '0;
            init_q       <= '0;
            col_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            w_q          <= w_d;
            h_q          <= h_d;
            x_q          <= x_d;
            row_q        <= row_d;
            wr_line_q    <= wr_line_d;
            col_q        <= col_d;
            ptr_q        <= ptr_d;
            init_q       <= init_d;
            col_valid_q  <= col_valid_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign bus.pix_ready    = ready;
    assign bus.busy         = busy;
    assign bus.col_out      = col_q;
    assign bus.col_valid    = col_valid_q;
    assign bus.col_ptr      = ptr_q;
    assign bus.init_col_ptr = init_q;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: K=3, K=5 and K=2 instances, scoreboard of expected columns
// built from the raster index, plus a spot-check vector table and control corner cases.
module tb_line_buffer_ctrl;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] st, vld;
    logic [7:0] wv [3];
    logic [7:0] hv [3];
    logic [7:0] dat [3];

    logic [39:0] colw [3];
    logic [2:0]  pt [3];
    logic [2:0]  ip [3];
    logic [2:0]  cv, fd, ce, rdy, bsy;

    line_buffer_ctrl_if #(.KER_SIZE(3), .BITWIDTH(8), .AW(8)) if3 ();
    line_buffer_ctrl_if #(.KER_SIZE(5), .BITWIDTH(8), .AW(8)) if5 ();
    line_buffer_ctrl_if #(.KER_SIZE(2), .BITWIDTH(8), .AW(8)) if2 ();

    line_buffer_ctrl #(.KER_SIZE(3), .BITWIDTH(8), .AW(8)) u_dut3 (.clk(clk), .rstn(rstn), .bus(if3));
    line_buffer_ctrl #(.KER_SIZE(5), .BITWIDTH(8), .AW(8)) u_dut5 (.clk(clk), .rstn(rstn), .bus(if5));
    line_buffer_ctrl #(.KER_SIZE(2), .BITWIDTH(8), .AW(8)) u_dut2 (.clk(clk), .rstn(rstn), .bus(if2));

    assign if3.start = st[0];  assign if3.img_width = wv[0];  assign if3.img_height = hv[0];
    assign if5.start = st[1];  assign if5.img_width = wv[1];  assign if5.img_height = hv[1];
    assign if2.start = st[2];  assign if2.img_width = wv[2];  assign if2.img_height = hv[2];
    assign if3.pix_valid = vld[0];  assign if3.pix_data = dat[0];
    assign if5.pix_valid = vld[1];  assign if5.pix_data = dat[1];
    assign if2.pix_valid = vld[2];  assign if2.pix_data = dat[2];

    assign colw[0] = 40'(if3.col_out);  assign colw[1] = if5.col_out;
    assign colw[2] = 40'(if2.col_out);
    assign pt[0] = if3.col_ptr;  assign pt[1] = if5.col_ptr;  assign pt[2] = if2.col_ptr;
    assign ip[0] = if3.init_col_ptr;  assign ip[1] = if5.init_col_ptr;
    assign ip[2] = if2.init_col_ptr;
    assign cv  = {if2.col_valid, if5.col_valid, if3.col_valid};
    assign fd  = {if2.frame_done, if5.frame_done, if3.frame_done};
    assign ce  = {if2.cfg_err, if5.cfg_err, if3.cfg_err};
    assign rdy = {if2.pix_ready, if5.pix_ready, if3.pix_ready};
    assign bsy = {if2.busy, if5.busy, if3.busy};

    typedef struct {
        int          sel;
        logic [39:0] col;
        logic [2:0]  ptr;
        logic [2:0]  init;
        logic        done;
    } exp_t;

    typedef struct {
        int          sel;
        int          idx;
        logic [39:0] col;
        logic [2:0]  ptr;
        logic [2:0]  init;
        logic        done;
    } vec_t;

    exp_t sb [$];
    exp_t cap [$];
    vec_t vecs [$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cur_sel = 0;
    int   cfg_cnt [3] = '{0, 0, 0};
    int   kk [3] = '{3, 5, 2};
    logic [39:0] last_col [3];
    logic [2:0]  last_ptr [3];
    logic [2:0]  last_init [3];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each column, otherwise demands stable outputs.
    always @(negedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 3; i++) begin
                last_col[i]  = '0;
                last_ptr[i]  = '0;
                last_init[i] = '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cv[i]) begin
                    if (sb.size() == 0 || sb[0].sel != i) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_col dut%0d: got %0h, required no column", i,
                                 colw[i]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk($sformatf("sb_col dut%0d", i), colw[i], e.col);
                        chk($sformatf("sb_ptr dut%0d", i), 40'(pt[i]), 40'(e.ptr));
                        chk($sformatf("sb_init dut%0d", i), 40'(ip[i]), 40'(e.init));
                        chk($sformatf("sb_done dut%0d", i), 40'(fd[i]), 40'(e.done));
                    end
                    last_col[i]  = colw[i];
                    last_ptr[i]  = pt[i];
                    last_init[i] = ip[i];
                    if (i == cur_sel) cap.push_back('{i, colw[i], pt[i], ip[i], fd[i]});
                end else begin
                    chk($sformatf("hold_col dut%0d", i), colw[i], last_col[i]);
                    chk($sformatf("hold_ptr dut%0d", i), 40'(pt[i]), 40'(last_ptr[i]));
                    chk($sformatf("hold_init dut%0d", i), 40'(ip[i]), 40'(last_init[i]));
                    chk($sformatf("done_no_col dut%0d", i), 40'(fd[i]), 40'(0));
                end
                if (ce[i]) cfg_cnt[i]++;
            end
        end
    end

    task automatic run_frame(input int sel, input int w, input int h, input bit gap,
                             input bit stray, input int stop_at);
        int k;
        int tmo;
        k = kk[sel];
        cap.delete();
        cur_sel = sel;
        @(posedge clk); #1;
        st[sel] = 1'b1;
        wv[sel] = 8'(w);
        hv[sel] = 8'(h);
        @(posedge clk); #1;
        st[sel] = 1'b0;
        last_ptr[sel]  = '0;
        last_init[sel] = '0;
        chk("busy_after_start", 40'(bsy[sel]), 40'(1));
        for (int p = 0; p < w * h; p++) begin
            int r;
            int x;
            if (stop_at >= 0 && p == stop_at) return;
            r = p / w;
            x = p % w;
            tmo = 0;
            while (!rdy[sel] && tmo < 20) begin
                @(posedge clk); #1;
                tmo++;
            end
            if (!rdy[sel]) begin
                n_cmp++;
                n_err++;
                $display("FAIL ready_timeout: got pix_ready 0, required 1 at pixel %0d", p);
                return;
            end
            vld[sel] = 1'b1;
            dat[sel] = 8'(p);
            if (stray && p == 2 * w + 1) begin
                st[sel] = 1'b1;
                wv[sel] = 8'd2;
            end
            if (r >= k - 1) begin
                exp_t e;
                e.sel = sel;
                e.col = '0;
                for (int j = 0; j < k; j++) e.col[j*8 +: 8] = 8'((r - k + 1 + j) * w + x);
                e.ptr  = 3'(x % k);
                e.init = 3'((x < k - 1) ? x : k - 1);
                e.done = (p == w * h - 1);
                sb.push_back(e);
            end
            @(posedge clk); #1;
            vld[sel] = 1'b0;
            st[sel]  = 1'b0;
            if (p == w * h - 1) begin
                chk("ready_in_done", 40'(rdy[sel]), 40'(0));
                chk("busy_in_done", 40'(bsy[sel]), 40'(1));
            end
            if (gap) begin
                @(posedge clk); #1;
            end
        end
        tmo = 0;
        while (bsy[sel] && tmo < 5) begin
            @(posedge clk); #1;
            tmo++;
        end
        chk("busy_after_frame", 40'(bsy[sel]), 40'(0));
        chk("sb_drained", 40'(sb.size()), 40'(0));
    endtask

    task automatic apply_vecs(input int sel, input int ncols);
        chk($sformatf("col_count dut%0d", sel), 40'(cap.size()), 40'(ncols));
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].sel == sel) begin
                if (vecs[i].idx < cap.size()) begin
                    chk($sformatf("vec%0d_col", i), cap[vecs[i].idx].col, vecs[i].col);
                    chk($sformatf("vec%0d_ptr", i), 40'(cap[vecs[i].idx].ptr), 40'(vecs[i].ptr));
                    chk($sformatf("vec%0d_init", i), 40'(cap[vecs[i].idx].init),
                        40'(vecs[i].init));
                    chk($sformatf("vec%0d_done", i), 40'(cap[vecs[i].idx].done),
                        40'(vecs[i].done));
                end else begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL vec%0d_missing: got %0d columns, required index %0d", i,
                             cap.size(), vecs[i].idx);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_col"}, colw[i], '0);
            chk({tag, "_valid"}, 40'(cv[i]), 40'(0));
            chk({tag, "_ptr"}, 40'(pt[i]), 40'(0));
            chk({tag, "_init"}, 40'(ip[i]), 40'(0));
            chk({tag, "_busy"}, 40'(bsy[i]), 40'(0));
            chk({tag, "_ready"}, 40'(rdy[i]), 40'(0));
            chk({tag, "_cfg"}, 40'(ce[i]), 40'(0));
            chk({tag, "_done"}, 40'(fd[i]), 40'(0));
        end
    endtask

    initial begin
        st  = '0;
        vld = '0;
        for (int i = 0; i < 3; i++) begin
            wv[i]  = '0;
            hv[i]  = '0;
            dat[i] = '0;
        end
        // sel, capture index, column (slice 0 in low byte), col_ptr, init_col_ptr, frame_done
        vecs.push_back('{0, 0, 40'h00_0008_0400, 3'd0, 3'd0, 1'b0});
        vecs.push_back('{0, 3, 40'h00_000b_0703, 3'd0, 3'd2, 1'b0});
        vecs.push_back('{0, 5, 40'h00_000d_0905, 3'd1, 3'd1, 1'b0});
        vecs.push_back('{0, 7, 40'h00_000f_0b07, 3'd0, 3'd2, 1'b1});
        vecs.push_back('{1, 5, 40'h1d_1711_0b05, 3'd0, 3'd4, 1'b1});
        vecs.push_back('{2, 0, 40'h00_0000_0200, 3'd0, 3'd0, 1'b0});
        vecs.push_back('{2, 1, 40'h00_0000_0301, 3'd1, 3'd1, 1'b1});

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;

        run_frame(0, 4, 4, 1'b0, 1'b0, -1);
        apply_vecs(0, 8);
        run_frame(0, 4, 4, 1'b1, 1'b0, -1);
        apply_vecs(0, 8);
        run_frame(1, 6, 5, 1'b0, 1'b0, -1);
        apply_vecs(1, 6);
        run_frame(2, 2, 2, 1'b0, 1'b0, -1);
        apply_vecs(2, 2);

        // Illegal width for K=3
        @(posedge clk); #1;
        st[0] = 1'b1;
        wv[0] = 8'd2;
        hv[0] = 8'd4;
        @(posedge clk); #1;
        st[0] = 1'b0;
        chk("cfg_err_pulse", 40'(ce[0]), 40'(1));
        chk("cfg_err_busy", 40'(bsy[0]), 40'(0));
        @(posedge clk); #1;
        chk("cfg_err_clear", 40'(ce[0]), 40'(0));
        chk("cfg_err_idle", 40'(bsy[0]), 40'(0));
        chk("cfg_err_count", 40'(cfg_cnt[0]), 40'(1));

        run_frame(0, 4, 4, 1'b0, 1'b1, -1);
        apply_vecs(0, 8);
        chk("stray_start_no_err", 40'(cfg_cnt[0]), 40'(1));

        // Reset after row 2, x=0 has been accepted
        run_frame(0, 4, 4, 1'b0, 1'b0, 9);
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        sb.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        run_frame(0, 4, 4, 1'b0, 1'b0, -1);
        apply_vecs(0, 8);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
